// File: rtl/droid_commander.sv
// Host-to-droid command sequencer: issues one opcode per accepted command and returns a status/data response.
// Optional build macro SHUTDOWN_LOCK_EN: SHUTDOWN locks out every command except RESET until RESET is issued.
module droid_commander #(
  parameter int unsigned RSP_LAT = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_loc,
  output logic [3:0]  opcode,
  output logic [7:0]  DataIn,
  output logic [15:0] LocIn,
  input  logic [7:0]  DataOut,
  input  logic [15:0] GPS,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_WAIT_ARRIVE, S_DONE
  } state_t;

  localparam logic [3:0] OP_GOTO     = 4'b0110;
  localparam logic [3:0] OP_RESET    = 4'b1100;
  localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_LOCKED  = 2'b11;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] loc_q, loc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        blocked;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_query(input logic [3:0] op);
    is_query = (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
  endfunction

`ifdef SHUTDOWN_LOCK_EN
  logic lock_q, lock_d;
  assign blocked = lock_q && (cmd_op != OP_RESET);
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    loc_d        = loc_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
`ifdef SHUTDOWN_LOCK_EN
    lock_d       = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          loc_d  = cmd_loc;
          cnt_d  = '0;
          if (blocked) begin
            state_d      = S_DONE;
            rsp_data_d   = '0;
            rsp_status_d = ST_LOCKED;
          end else if (!is_legal(cmd_op)) begin
            state_d      = S_DONE;
            rsp_data_d   = '0;
            rsp_status_d = ST_ILLEGAL;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // cnt counts cycles since ISSUE, so WAIT_* cycle k sees cnt == k
        cnt_d = 8'd1;
`ifdef SHUTDOWN_LOCK_EN
        if (op_q == OP_SHUTDOWN) lock_d = 1'b1;
        if (op_q == OP_RESET)    lock_d = 1'b0;
`endif
        if (is_query(op_q)) begin
          state_d = S_WAIT_RSP;
        end else if (op_q == OP_GOTO) begin
          state_d = S_WAIT_ARRIVE;
        end else begin
          state_d      = S_DONE;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
        end
      end
      S_WAIT_RSP: begin
        if (cnt_q == 8'(RSP_LAT)) begin
          state_d      = S_DONE;
          rsp_data_d   = DataOut;
          rsp_status_d = ST_OK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_ARRIVE: begin
        // arrival wins over a timeout in the same cycle
        if (GPS == loc_q) begin
          state_d      = S_DONE;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d      = S_DONE;
          rsp_data_d   = '0;
          rsp_status_d = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      data_q       <= '0;
      loc_q        <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
`ifdef SHUTDOWN_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      loc_q        <= loc_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
`ifdef SHUTDOWN_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign opcode     = (state_q == S_ISSUE) ? op_q : 4'b0000;
  assign rsp_valid  = (state_q == S_DONE);
  assign DataIn     = data_q;
  assign LocIn      = loc_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_droid_commander.sv
// Randomized bench for droid_commander against a transaction-level model of the command protocol.
module tb_droid_commander;
  localparam int unsigned RSP_LAT = 2;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_loc;
  logic [3:0]  opcode;
  logic [7:0]  DataIn;
  logic [15:0] LocIn;
  logic [7:0]  DataOut;
  logic [15:0] GPS;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          model_lock = 1'b0;
  logic [7:0]  dout_hist [0:31];

  droid_commander #(.RSP_LAT(RSP_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_loc(cmd_loc), .opcode(opcode),
    .DataIn(DataIn), .LocIn(LocIn), .DataOut(DataOut), .GPS(GPS),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // arrive: index of the first post-issue cycle where GPS equals the target (0 = never).
  // dforce[8]: hold DataOut at dforce[7:0] instead of randomizing it.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] d, input logic [15:0] loc,
                         input int unsigned hold, input int unsigned arrive, input logic [8:0] dforce);
    int unsigned exp_c;
    logic [1:0]  exp_st;
    logic [7:0]  exp_data;
    bit          issued;
    bit          blocked;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_loc = loc;
    tick();
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_data = 8'($urandom); cmd_loc = 16'($urandom);
    issued = 1'b0; exp_data = 8'h00;
`ifdef SHUTDOWN_LOCK_EN
    blocked = model_lock && (op != 4'hC);
`else
    blocked = 1'b0;
`endif
    if (blocked) begin
      exp_c = 1; exp_st = 2'b11;
    end else if (!op_legal(op)) begin
      exp_c = 1; exp_st = 2'b10;
    end else begin
      issued = 1'b1;
      exp_st = 2'b00;
      if (op == 4'd8 || op == 4'd9 || op == 4'd10) begin
        exp_c = RSP_LAT + 2;
      end else if (op == 4'd6) begin
        if (arrive != 0 && arrive <= TIMEOUT) exp_c = arrive + 2;
        else begin exp_c = TIMEOUT + 2; exp_st = 2'b01; end
      end else begin
        exp_c = 2;
      end
    end
    for (int unsigned c = 1; c <= exp_c; c++) begin
      DataOut = dforce[8] ? dforce[7:0] : 8'($urandom);
      if (c < 32) dout_hist[c] = DataOut;
      GPS = (arrive != 0 && c >= arrive + 1) ? loc : (loc ^ 16'($urandom_range(1, 65535)));
      rsp_ready = (c == exp_c) ? (hold == 0) : 1'($urandom_range(0, 1));
      check("opcode", 32'(opcode), (issued && c == 1) ? 32'(op) : 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(c == exp_c));
      if (c != exp_c) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (c == 1) begin
        check("DataIn", 32'(DataIn), 32'(d));
        check("LocIn", 32'(LocIn), 32'(loc));
      end
      if (c < exp_c) tick();
    end
    if (issued && (op == 4'd8 || op == 4'd9 || op == 4'd10)) exp_data = dout_hist[RSP_LAT + 1];
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_status", 32'(rsp_status), 32'(exp_st));
    check("cmd_ready_done", 32'(cmd_ready), 32'd0);
    for (int unsigned h = 1; h <= hold; h++) begin
      tick();
      rsp_ready = (h == hold);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(exp_data));
      check("hold_status", 32'(rsp_status), 32'(exp_st));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_opcode", 32'(opcode), 32'd0);
    end
    tick();
    rsp_ready = 1'b0;
    check("back_idle_ready", 32'(cmd_ready), 32'd1);
    check("back_idle_valid", 32'(rsp_valid), 32'd0);
    check("DataIn_held", 32'(DataIn), 32'(d));
    check("LocIn_held", 32'(LocIn), 32'(loc));
    if (issued && op == 4'hD) model_lock = 1'b1;
    if (issued && op == 4'hC) model_lock = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_DataIn", 32'(DataIn), 32'd0);
    check("rst_LocIn", 32'(LocIn), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_loc = '0;
    DataOut = '0; GPS = '0; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_values();

    run_cmd(4'd9, 8'h11, 16'h2222, 0, 0, 9'h15A);
    run_cmd(4'd6, 8'h00, 16'h0304, 0, 10, 9'h000);
    run_cmd(4'd6, 8'h00, 16'h0304, 0, 0, 9'h000);
    run_cmd(4'd6, 8'h42, 16'hBEEF, 1, TIMEOUT, 9'h000);
    run_cmd(4'd3, 8'h33, 16'h1234, 0, 0, 9'h000);
    run_cmd(4'd5, 8'h77, 16'h4321, 5, 0, 9'h000);
    run_cmd(4'd13, 8'h01, 16'h0001, 0, 0, 9'h000);
`ifdef SHUTDOWN_LOCK_EN
    run_cmd(4'd5, 8'h02, 16'h0002, 0, 0, 9'h000);
    run_cmd(4'd12, 8'h03, 16'h0003, 0, 0, 9'h000);
    run_cmd(4'd5, 8'h04, 16'h0004, 0, 0, 9'h000);
`endif

    cmd_valid = 1'b1; cmd_op = 4'd6; cmd_data = 8'hA5; cmd_loc = 16'h5555;
    GPS = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
    check("pre_reset_busy", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_lock = 1'b0;
    check_reset_values();
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("post_reset_valid", 32'(rsp_valid), 32'd0);
      check("post_reset_opcode", 32'(opcode), 32'd0);
    end

    for (int unsigned n = 0; n < 60; n++) begin
      int unsigned arr;
      arr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      run_cmd(4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom),
              $urandom_range(0, 4), arr, 9'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
